// File: rtl/act_write_back.sv
// Activation write-back buffer: MAC results land here, the MAC stage reads
// them back, and an FSM can bulk-clear the array or stream it out.
module act_write_back #(
  parameter int DATA_WIDTH = 16,
  parameter int ACT_NUM    = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  comp_en_wb,
  input  logic [ADDR_WIDTH-1:0] out_act_addr_wb,
  input  logic [DATA_WIDTH-1:0] mac_result_wb,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_value,
  input  logic                  clr_start,
  input  logic                  drain_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  wb_err
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(ACT_NUM - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_EXT = (ADDR_WIDTH + 1)'(ACT_NUM);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   arr_q [ACT_NUM];
  logic [DATA_WIDTH-1:0]   arr_d [ACT_NUM];
  logic [DATA_WIDTH-1:0]   rd_value_q, rd_value_d;
  logic                    wb_err_q, wb_err_d;

  logic wb_in_range, rd_in_range, wb_acc;

  assign wb_in_range = {1'b0, out_act_addr_wb} < NUM_EXT;
  assign rd_in_range = {1'b0, rd_addr} < NUM_EXT;
  assign wb_acc      = (state_q == IDLE) && comp_en_wb && wb_in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arr_d    = arr_q;
    wb_err_d = wb_err_q | (comp_en_wb && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (wb_acc) arr_d[out_act_addr_wb] = mac_result_wb;
        // Clear has priority; a coincident drain request is simply lost.
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (drain_start) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        arr_d[cnt_q] = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reading the next-state array gives write forwarding and clear-zeroing for free.
    rd_value_d = (rd_en && rd_in_range) ? arr_d[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_value_q <= '0;
      wb_err_q   <= 1'b0;
      for (int i = 0; i < ACT_NUM; i++) arr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_value_q <= rd_value_d;
      wb_err_q   <= wb_err_d;
      arr_q      <= arr_d;
    end
  end

  assign rd_value  = rd_value_q;
  assign wb_err    = wb_err_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_addr  = out_valid ? cnt_q : '0;
  assign out_data  = out_valid ? arr_q[cnt_q] : '0;

endmodule

// File: doc/act_write_back.md
ACT_WRITE_BACK -- requirements
Module: act_write_back

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the activation/MAC result width in bits.
REQ-002 SHALL have parameter ACT_NUM, default 16, the number of output activation entries.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, the address width, with ACT_NUM <= 2^ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port comp_en_wb, input, 1 bit: the write-back request from the MAC stage.
REQ-007 SHALL have port out_act_addr_wb, input, ADDR_WIDTH bits: the write-back address.
REQ-008 SHALL have port mac_result_wb, input, DATA_WIDTH bits: the write-back data.
REQ-009 SHALL have port rd_en, input, 1 bit: the read request from the read stage.
REQ-010 SHALL have port rd_addr, input, ADDR_WIDTH bits: the read address.
REQ-011 SHALL have port rd_value, output, DATA_WIDTH bits: the read data; it feeds the out_act_value_mac input of the MAC stage.
REQ-012 SHALL have port clr_start, input, 1 bit: a single-cycle pulse requesting that all entries be cleared to zero.
REQ-013 SHALL have port drain_start, input, 1 bit: a single-cycle pulse requesting that all entries be streamed out.
REQ-014 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_addr (output, ADDR_WIDTH bits) and out_data (output, DATA_WIDTH bits), forming the drain stream.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port wb_err, output, 1 bit: a sticky flag for dropped write-backs.

Function
REQ-017 SHALL hold ACT_NUM x DATA_WIDTH registers (the activation array).
REQ-018 SHALL, in IDLE when comp_en_wb=1, write mac_result_wb to entry out_act_addr_wb at the clock edge.
REQ-019 SHALL ignore a write-back whose address is >= ACT_NUM.
REQ-020 SHALL register rd_value with 1-cycle latency: rd_en=1 at cycle N gives the entry value at cycle N+1; rd_en=0 at cycle N gives rd_value=0 at cycle N+1.
REQ-021 SHALL forward on a same-cycle collision: rd_en=1, comp_en_wb=1 (write accepted) and rd_addr==out_act_addr_wb give rd_value=mac_result_wb next cycle, never the stale value.
REQ-022 SHALL implement FSM states IDLE, CLEAR and DRAIN.
REQ-023 SHALL transition from IDLE to CLEAR on clr_start and from IDLE to DRAIN on drain_start; if both are asserted in the same cycle, CLEAR wins and drain_start is dropped.
REQ-024 SHALL ignore clr_start and drain_start outside IDLE.
REQ-025 SHALL, in CLEAR, zero one entry per cycle from index 0 up to ACT_NUM-1 using an internal counter, then return to IDLE: exactly ACT_NUM cycles with busy=1.
REQ-026 SHALL, in DRAIN, present entry k with out_valid=1, out_addr=k and out_data=array[k], starting at k=0.
REQ-027 SHALL advance k only on out_valid&&out_ready.
REQ-028 SHALL hold out_addr and out_data stable while out_valid=1 and out_ready=0.
REQ-029 SHALL, after the handshake at k=ACT_NUM-1, deassert out_valid in the next cycle and enter IDLE.
REQ-030 SHALL drive out_valid=0 in IDLE and CLEAR, with out_addr=0 and out_data=0.
REQ-031 SHALL, while in CLEAR or DRAIN, drop comp_en_wb=1 (array unchanged) and set wb_err=1; wb_err stays set until reset.
REQ-032 SHALL serve reads (REQ-020) in every state; during CLEAR a read returns the array content before that cycle's clear write, except that a read of the entry being cleared that cycle returns 0.
REQ-033 SHALL have no combinational path from any input to any output except out_data/out_addr, which are a function of registered state only.

Reset
REQ-034 SHALL, while rst_n=0 (asynchronously), force FSM=IDLE, counter=0, rd_value=0, out_valid=0, out_addr=0, out_data=0, busy=0, wb_err=0 and all array entries to 0.
REQ-035 SHALL, on rst_n assertion mid-CLEAR or mid-DRAIN, abort the operation with no further stream beats after reset release.

Verification
REQ-036 SHALL cover: write 0x1234 to addr 3, then rd_en on addr 3 the next cycle -> rd_value=0x1234 one cycle later.
REQ-037 SHALL cover: same-cycle write 0x00AB to addr 5 with rd_en addr 5 (old value 0x0011) -> rd_value=0x00AB next cycle.
REQ-038 SHALL cover: fill all 16 entries with value=index, drain_start, out_ready toggling 1,0,1,... -> 16 beats with addr/data 0..15 in order, held stable during stalls, then busy=0.
REQ-039 SHALL cover: clr_start and drain_start in the same cycle -> busy for exactly 16 cycles, no out_valid, all reads return 0 afterwards.
REQ-040 SHALL cover: comp_en_wb during DRAIN -> array unchanged, wb_err=1 and stays set until rst_n=0.
REQ-041 SHALL cover: rst_n=0 during beat 7 of a drain -> out_valid=0 immediately, IDLE and all entries 0 after release.
